// File: rtl/multiplier_axi4_lite_slave_if.sv
`default_nettype none
// ============================================================================
// Module  : multiplier_axi4_lite_slave_if
// Brief   : AXI4-Lite bus bundle for the shift-add multiplier slave, with
//           master (bus driver) and slave (register block) views.
// Revision: 1.0 - initial release
// ============================================================================
interface multiplier_axi4_lite_slave_if #(
  parameter int C_S_AXI_ADDR_WIDTH = 32
);
  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR;
  logic                          S_AXI_AWVALID;
  logic                          S_AXI_AWREADY;
  logic [31:0]                   S_AXI_WDATA;
  logic [3:0]                    S_AXI_WSTRB;
  logic                          S_AXI_WVALID;
  logic                          S_AXI_WREADY;
  logic [1:0]                    S_AXI_BRESP;
  logic                          S_AXI_BVALID;
  logic                          S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic                          S_AXI_ARVALID;
  logic                          S_AXI_ARREADY;
  logic [31:0]                   S_AXI_RDATA;
  logic [1:0]                    S_AXI_RRESP;
  logic                          S_AXI_RVALID;
  logic                          S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface
`default_nettype wire

// File: rtl/multiplier_axi4_lite_slave.sv
`default_nettype none
// ============================================================================
// Module  : multiplier_axi4_lite_slave
// Brief   : AXI4-Lite register block around a sequential unsigned shift-add
//           multiplier (A, B, START/busy, P, DONE). Only address bits [4:2]
//           are decoded. Optional macro MULT_SLVERR_EN makes unmapped
//           offsets answer SLVERR instead of OKAY.
// Revision: 1.0 - initial release
// ============================================================================
module multiplier_axi4_lite_slave #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int OP_W               = 16
) (
  input  wire logic                           S_AXI_ACLK,
  input  wire logic                           S_AXI_ARESET,
  multiplier_axi4_lite_slave_if.slave         s_axi
);

  localparam int              P_W       = 2 * OP_W;
  localparam int              CNT_W     = $clog2(OP_W + 1);
  localparam logic [CNT_W-1:0] LAST_IT  = CNT_W'(OP_W - 1);
  localparam logic [2:0]      IDX_A     = 3'd0;
  localparam logic [2:0]      IDX_B     = 3'd1;
  localparam logic [2:0]      IDX_START = 3'd2;
  localparam logic [2:0]      IDX_P     = 3'd3;
  localparam logic [2:0]      IDX_DONE  = 3'd4;
  localparam logic [1:0]      RESP_OKAY = 2'b00;
`ifdef MULT_SLVERR_EN
  localparam logic [1:0]      RESP_ERR  = 2'b10;
`endif

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIN = 2'd2} state_t;

  // AXI side registers
  logic              awready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]        bresp_q, rresp_q;
  logic [31:0]       rdata_q;
  logic [OP_W-1:0]   a_q, b_q;

  // Multiplier registers
  state_t            state_q, state_d;
  logic [P_W-1:0]    mcand_q, mcand_d, p_q, p_d;
  logic [OP_W-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;

  logic              wr_hs, rd_hs, start_req, busy;
  logic [2:0]        wr_idx, rd_idx;
  logic [1:0]        wr_resp, rd_resp;
  logic [31:0]       rd_val;
  logic              unused_ok;

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = awready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;

  // Handshakes complete on the edge where the one-cycle ready pulse meets valid
  assign wr_hs     = awready_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
  assign rd_hs     = arready_q & s_axi.S_AXI_ARVALID;
  assign wr_idx    = s_axi.S_AXI_AWADDR[4:2];
  assign rd_idx    = s_axi.S_AXI_ARADDR[4:2];
  assign start_req = wr_hs & (wr_idx == IDX_START) & s_axi.S_AXI_WDATA[0];
  assign busy      = (state_q == S_RUN);

  // Address/data bits outside the decoded field are intentionally ignored
  assign unused_ok = &{1'b0, s_axi.S_AXI_AWADDR, s_axi.S_AXI_ARADDR,
                       s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB};

`ifdef MULT_SLVERR_EN
  assign wr_resp = (wr_idx > IDX_DONE) ? RESP_ERR : RESP_OKAY;
  assign rd_resp = (rd_idx > IDX_DONE) ? RESP_ERR : RESP_OKAY;
`else
  assign wr_resp = RESP_OKAY;
  assign rd_resp = RESP_OKAY;
`endif

  // Byte-lane merge of write data into an operand register
  function automatic logic [OP_W-1:0] merge_bytes(input logic [OP_W-1:0] old_v,
                                                  input logic [31:0]     data,
                                                  input logic [3:0]      strb);
    logic [OP_W-1:0] res;
    res = old_v;
    for (int i = 0; i < OP_W; i++) begin
      if (strb[i/8]) res[i] = data[i];
    end
    return res;
  endfunction

  // Read data mux; unmapped offsets read as zero
  always_comb begin
    rd_val = '0;
    case (rd_idx)
      IDX_A:     rd_val = 32'(a_q);
      IDX_B:     rd_val = 32'(b_q);
      IDX_START: rd_val = {31'd0, busy};
      IDX_P:     rd_val = 32'(p_q);
      IDX_DONE:  rd_val = {31'd0, done_q};
      default:   rd_val = '0;
    endcase
  end

  // AXI write/read channels and the A/B operand registers
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      awready_q <= ~awready_q & ~bvalid_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_resp;
        if (wr_idx == IDX_A) a_q <= merge_bytes(a_q, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
        if (wr_idx == IDX_B) b_q <= merge_bytes(b_q, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
      end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end

      arready_q <= ~arready_q & ~rvalid_q & s_axi.S_AXI_ARVALID;
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
        rresp_q  <= rd_resp;
      end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Multiplier state and datapath registers
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  // Next state: one shift-add per RUN cycle, START accepted whenever not running
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    case (state_q)
      S_RUN: begin
        if (mplier_q[0]) p_d = p_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_IT) state_d = S_FIN;
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: ;
    endcase
    if (start_req && state_q != S_RUN) begin
      state_d  = S_RUN;
      mcand_d  = P_W'(a_q);
      mplier_d = b_q;
      p_d      = '0;
      cnt_d    = '0;
      done_d   = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multiplier_axi4_lite_slave.sv
`default_nettype none
// ============================================================================
// Module  : tb_multiplier_axi4_lite_slave
// Brief   : Directed self-checking bench for multiplier_axi4_lite_slave.
// Revision: 1.0 - initial release
// ============================================================================
module tb_multiplier_axi4_lite_slave;

  localparam logic [31:0] ADDR_A = 32'h00, ADDR_B = 32'h04, ADDR_START = 32'h08;
  localparam logic [31:0] ADDR_P = 32'h0C, ADDR_DONE = 32'h10;
`ifdef MULT_SLVERR_EN
  localparam logic [1:0] EXP_UNMAP = 2'b10;
`else
  localparam logic [1:0] EXP_UNMAP = 2'b00;
`endif

  logic clk, rst;
  int   n_checks, n_errors;

  multiplier_axi4_lite_slave_if #(.C_S_AXI_ADDR_WIDTH(32)) bus ();

  multiplier_axi4_lite_slave #(.C_S_AXI_ADDR_WIDTH(32), .OP_W(16)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .s_axi        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    @(negedge clk);
    bus.S_AXI_AWADDR = addr; bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    @(negedge clk);
    n = 0;
    while (!bus.S_AXI_AWREADY && n < 50) begin @(negedge clk); n++; end
    if (!bus.S_AXI_AWREADY) begin
      check("aw_timeout", 32'd0, 32'd1);
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; resp = 2'b11;
      return;
    end
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b1;
    n = 0;
    while (!bus.S_AXI_BVALID && n < 50) begin @(negedge clk); n++; end
    if (!bus.S_AXI_BVALID) check("b_timeout", 32'd0, 32'd1);
    resp = bus.S_AXI_BRESP;
    @(negedge clk);
    bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    @(negedge clk);
    bus.S_AXI_ARADDR = addr; bus.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    n = 0;
    while (!bus.S_AXI_ARREADY && n < 50) begin @(negedge clk); n++; end
    if (!bus.S_AXI_ARREADY) begin
      check("ar_timeout", 32'd0, 32'd1);
      bus.S_AXI_ARVALID = 1'b0; data = 32'hDEAD_DEAD; resp = 2'b11;
      return;
    end
    @(negedge clk);
    bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b1;
    n = 0;
    while (!bus.S_AXI_RVALID && n < 50) begin @(negedge clk); n++; end
    if (!bus.S_AXI_RVALID) check("r_timeout", 32'd0, 32'd1);
    data = bus.S_AXI_RDATA; resp = bus.S_AXI_RRESP;
    @(negedge clk);
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [1:0] resp;
    axi_write(addr, data, 4'hF, resp);
    check("wr_resp", 32'(resp), 32'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  resp;
    axi_read(addr, d, resp);
    check(tag, d, exp);
  endtask

  task automatic poll_done();
    logic [31:0] d;
    logic [1:0]  resp;
    int n;
    n = 0;
    d = 32'd0;
    while (d[0] == 1'b0 && n < 20) begin axi_read(ADDR_DONE, d, resp); n++; end
    check("poll_done", d, 32'd1);
  endtask

  typedef struct { logic [15:0] a; logic [15:0] b; logic [31:0] p; } vec_t;
  vec_t vecs[4];

  initial begin
    logic [1:0] resp;
    n_checks = 0; n_errors = 0;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WDATA = '0;
    bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_flags", {26'd0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
                        bus.S_AXI_ARREADY, bus.S_AXI_RVALID, 1'b0}, 32'd0);
    check("rst_rdata", bus.S_AXI_RDATA, 32'd0);
    rd_chk("rst_A", ADDR_A, 32'd0);
    rd_chk("rst_P", ADDR_P, 32'd0);
    rd_chk("rst_DONE", ADDR_DONE, 32'd0);

    // 15 * 15
    wr(ADDR_A, 32'd15); wr(ADDR_B, 32'd15); wr(ADDR_START, 32'd1);
    rd_chk("busy_run1", ADDR_START, 32'd1);
    repeat (20) @(negedge clk);
    rd_chk("done_15x15", ADDR_DONE, 32'd1);
    rd_chk("p_15x15", ADDR_P, 32'h0000_00E1);

    // Max operands
    wr(ADDR_A, 32'hFFFF); wr(ADDR_B, 32'hFFFF); wr(ADDR_START, 32'd1);
    rd_chk("done_cleared", ADDR_DONE, 32'd0);
    rd_chk("busy_run2", ADDR_START, 32'd1);
    poll_done();
    rd_chk("p_max", ADDR_P, 32'hFFFE_0001);
    rd_chk("busy_after", ADDR_START, 32'd0);

    // A write and second START during RUN are ignored by the running operation
    wr(ADDR_A, 32'd7); wr(ADDR_B, 32'd9); wr(ADDR_START, 32'd1);
    wr(ADDR_A, 32'd3); wr(ADDR_START, 32'd1);
    poll_done();
    rd_chk("p_latched", ADDR_P, 32'd63);
    rd_chk("a_rw_during_run", ADDR_A, 32'd3);

    // Further patterns
    vecs[0] = '{16'h0000, 16'h1234, 32'h0000_0000};
    vecs[1] = '{16'h0001, 16'hFFFF, 32'h0000_FFFF};
    vecs[2] = '{16'h8000, 16'h0002, 32'h0001_0000};
    vecs[3] = '{16'h1234, 16'h0010, 32'h0001_2340};
    for (int i = 0; i < 4; i++) begin
      wr(ADDR_A, 32'(vecs[i].a)); wr(ADDR_B, 32'(vecs[i].b)); wr(ADDR_START, 32'd1);
      poll_done();
      rd_chk($sformatf("p_vec%0d", i), ADDR_P, vecs[i].p);
    end

    // START with bit0 clear does nothing; done stays sticky
    wr(ADDR_START, 32'h2);
    rd_chk("start0_busy", ADDR_START, 32'd0);
    rd_chk("start0_done", ADDR_DONE, 32'd1);

    // Byte strobes
    wr(ADDR_A, 32'hABCD);
    axi_write(ADDR_A, 32'h0000_1234, 4'b0001, resp);
    rd_chk("wstrb_A", ADDR_A, 32'h0000_AB34);
    wr(ADDR_B, 32'h1111);
    axi_write(ADDR_B, 32'h0000_5600, 4'b0010, resp);
    rd_chk("wstrb_B", ADDR_B, 32'h0000_5611);

    // Write response stall with valids still asserted
    begin
      int n;
      @(negedge clk);
      bus.S_AXI_AWADDR = ADDR_B; bus.S_AXI_WDATA = 32'h2222; bus.S_AXI_WSTRB = 4'hF;
      bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
      @(negedge clk);
      n = 0;
      while (!bus.S_AXI_AWREADY && n < 50) begin @(negedge clk); n++; end
      check("stall_aw_seen", 32'(bus.S_AXI_AWREADY), 32'd1);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        check("stall_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
        check("stall_no_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
        @(negedge clk);
      end
      check("stall_bresp", 32'(bus.S_AXI_BRESP), 32'd0);
      bus.S_AXI_BREADY = 1'b1; bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      @(negedge clk);
      bus.S_AXI_BREADY = 1'b0;
      check("stall_bvalid_clr", 32'(bus.S_AXI_BVALID), 32'd0);
    end
    rd_chk("stall_B", ADDR_B, 32'h2222);

    // Read data stall with ARVALID still asserted
    begin
      int n;
      @(negedge clk);
      bus.S_AXI_ARADDR = ADDR_B; bus.S_AXI_ARVALID = 1'b1;
      @(negedge clk);
      n = 0;
      while (!bus.S_AXI_ARREADY && n < 50) begin @(negedge clk); n++; end
      check("stall_ar_seen", 32'(bus.S_AXI_ARREADY), 32'd1);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        check("stall_rvalid", 32'(bus.S_AXI_RVALID), 32'd1);
        check("stall_rdata", bus.S_AXI_RDATA, 32'h2222);
        check("stall_no_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
        @(negedge clk);
      end
      bus.S_AXI_RREADY = 1'b1; bus.S_AXI_ARVALID = 1'b0;
      @(negedge clk);
      bus.S_AXI_RREADY = 1'b0;
      check("stall_rvalid_clr", 32'(bus.S_AXI_RVALID), 32'd0);
    end

    // Reset mid-RUN aborts, then a fresh operation completes
    wr(ADDR_A, 32'd100); wr(ADDR_B, 32'd200); wr(ADDR_START, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd_chk("rst_run_DONE", ADDR_DONE, 32'd0);
    rd_chk("rst_run_P", ADDR_P, 32'd0);
    rd_chk("rst_run_busy", ADDR_START, 32'd0);
    rd_chk("rst_run_A", ADDR_A, 32'd0);
    wr(ADDR_A, 32'd3); wr(ADDR_B, 32'd4); wr(ADDR_START, 32'd1);
    repeat (20) @(negedge clk);
    rd_chk("after_rst_DONE", ADDR_DONE, 32'd1);
    rd_chk("after_rst_P", ADDR_P, 32'd12);

    // Writes to RO/unmapped offsets ignored; unmapped reads return zero
    wr(ADDR_P, 32'hDEAD_BEEF);
    wr(ADDR_DONE, 32'h0);
    rd_chk("ro_P", ADDR_P, 32'd12);
    rd_chk("ro_DONE", ADDR_DONE, 32'd1);
    axi_write(32'h18, 32'hFFFF_FFFF, 4'hF, resp);
    check("unmap_bresp", 32'(resp), 32'(EXP_UNMAP));
    begin
      logic [31:0] d;
      axi_read(32'h14, d, resp);
      check("unmap_rdata", d, 32'd0);
      check("unmap_rresp", 32'(resp), 32'(EXP_UNMAP));
    end
    rd_chk("unmap_A_kept", ADDR_A, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
